// File: rtl/mem_resp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mem_resp_pkg                                                  |
// | Brief  : Shared FSM state, direction and word-size definitions for the |
// |          mem_responder bus responder and its RAM.                      |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  localparam int WORD_BYTES = 8;
  localparam int CNT_W      = 4;   // holds LAT-1 for LAT up to 15

  // A bus address must land on a word boundary.
  function automatic logic is_misaligned(input logic [63:0] addr);
    return addr[$clog2(WORD_BYTES)-1:0] != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mem_resp_ram                                                  |
// | Brief  : 1R1W synchronous DEPTH x 64 word RAM, write-first on a        |
// |          same-address collision. Read data holds while re is low.      |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module mem_resp_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata
);

  logic [63:0] mem [DEPTH];
  logic [63:0] rdata_q;
  logic [63:0] rdata_d;

  // Next read word: new write data wins over the stored word on collision.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      if (we && (waddr == raddr)) rdata_d = wdata;
      else                        rdata_d = mem[raddr];
    end
  end

  // Storage array is never reset so preloaded contents survive a reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mem_responder                                                 |
// | Brief  : Bus responder answering read/write beats from a local 64-bit  |
// |          word memory, with a host preload/inspect port.                |
// |          Optional: define MEM_RESP_STATS_EN to add rd_beats/wr_beats   |
// |          saturating beat counters.                                     |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH = 64,
  parameter int          LAT   = 2,
  parameter logic [63:0] BASE  = 64'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_enable,
  input  logic [63:0]              read_addr,
  input  logic [63:0]              read_size_output,
  input  logic                     finish_read,
  input  logic                     write_enable,
  input  logic [63:0]              write_addr,
  input  logic [63:0]              write_data,
  input  logic [63:0]              write_size,
  input  logic                     finish_write,
  output logic [63:0]              read_ready,
  output logic [63:0]              read_data,
  output logic [63:0]              write_ready,
  input  logic                     host_en,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [63:0]              host_wdata,
  output logic [63:0]              host_rdata,
  output logic                     host_ack,
`ifdef MEM_RESP_STATS_EN
  output logic [31:0]              rd_beats,
  output logic [31:0]              wr_beats,
`endif
  output logic                     err
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             bad_q, bad_d;
  logic [63:0]      data_q, data_d;
  logic             rd_rdy_q, rd_rdy_d;
  logic             wr_rdy_q, wr_rdy_d;
  logic             host_ack_q, host_ack_d;
  logic             err_q, err_d;

  logic             ram_re, ram_we;
  logic [AW-1:0]    ram_raddr, ram_waddr;
  logic [63:0]      ram_wdata, ram_rdata;

  // Word index and range/alignment check for each incoming address.
  logic [63:0]      rd_off, wr_off;
  logic [AW-1:0]    rd_idx, wr_idx;
  logic             rd_bad, wr_bad;
  logic             unused_ok;

  assign rd_off = read_addr - BASE;
  assign wr_off = write_addr - BASE;
  assign rd_idx = rd_off[AW+2:3];
  assign wr_idx = wr_off[AW+2:3];
  assign rd_bad = (rd_off[63:3] >= 61'(DEPTH)) || is_misaligned(read_addr);
  assign wr_bad = (wr_off[63:3] >= 61'(DEPTH)) || is_misaligned(write_addr);
  // Strides only describe the initiator's walk; indexing uses the address.
  assign unused_ok = ^{read_size_output, write_size, rd_off[2:0], wr_off[2:0]};

  // Next-state, beat latching and RAM arbitration between bus and host.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    bad_d      = bad_q;
    data_d     = data_q;
    rd_rdy_d   = 1'b0;
    wr_rdy_d   = 1'b0;
    host_ack_d = 1'b0;
    err_d      = err_q;
    ram_re     = 1'b0;
    ram_raddr  = idx_q;
    ram_we     = 1'b0;
    ram_waddr  = idx_q;
    ram_wdata  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (read_enable) begin
          idx_d   = rd_idx;
          bad_d   = rd_bad;
          dir_d   = DIR_RD;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end else if (write_enable) begin
          idx_d   = wr_idx;
          bad_d   = wr_bad;
          data_d  = write_data;
          dir_d   = DIR_WR;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end else if (host_en) begin
          host_ack_d = 1'b1;
          if (host_we) begin
            ram_we    = 1'b1;
            ram_waddr = host_addr;
            ram_wdata = host_wdata;
          end else begin
            ram_re    = 1'b1;
            ram_raddr = host_addr;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Ready is registered here so it is high for the whole BEAT cycle;
          // the RAM read is launched now so its data lines up with it.
          state_d = ST_BEAT;
          if (dir_q == DIR_RD) begin
            rd_rdy_d = 1'b1;
            ram_re   = 1'b1;
          end else begin
            wr_rdy_d = 1'b1;
          end
          if (bad_q) err_d = 1'b1;
        end
      end
      ST_BEAT: begin
        if ((dir_q == DIR_WR) && !bad_q) ram_we = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (dir_q == DIR_RD) begin
          if (finish_read) begin
            idx_d   = rd_idx;
            bad_d   = rd_bad;
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end else if (!read_enable) begin
            state_d = ST_IDLE;
          end
        end else begin
          if (finish_write) begin
            idx_d   = wr_idx;
            bad_d   = wr_bad;
            data_d  = write_data;
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end else if (!write_enable) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and handshake registers; reset aborts any handshake at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_RD;
      cnt_q      <= '0;
      idx_q      <= '0;
      bad_q      <= 1'b0;
      data_q     <= '0;
      rd_rdy_q   <= 1'b0;
      wr_rdy_q   <= 1'b0;
      host_ack_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      bad_q      <= bad_d;
      data_q     <= data_d;
      rd_rdy_q   <= rd_rdy_d;
      wr_rdy_q   <= wr_rdy_d;
      host_ack_q <= host_ack_d;
      err_q      <= err_d;
    end
  end

  mem_resp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata)
  );

  assign read_ready  = {63'd0, rd_rdy_q};
  assign write_ready = {63'd0, wr_rdy_q};
  assign read_data   = ((state_q == ST_BEAT) && (dir_q == DIR_RD) && !bad_q) ? ram_rdata : '0;
  assign host_ack    = host_ack_q;
  assign host_rdata  = host_ack_q ? ram_rdata : '0;
  assign err         = err_q;

`ifdef MEM_RESP_STATS_EN
  logic [31:0] rd_beats_q, rd_beats_d;
  logic [31:0] wr_beats_q, wr_beats_d;

  // Saturating per-direction beat counters, bumped once per BEAT cycle.
  always_comb begin
    rd_beats_d = rd_beats_q;
    wr_beats_d = wr_beats_q;
    if (state_q == ST_BEAT) begin
      if ((dir_q == DIR_RD) && (rd_beats_q != '1)) rd_beats_d = rd_beats_q + 32'd1;
      if ((dir_q == DIR_WR) && (wr_beats_q != '1)) wr_beats_d = wr_beats_q + 32'd1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_beats_q <= '0;
      wr_beats_q <= '0;
    end else begin
      rd_beats_q <= rd_beats_d;
      wr_beats_q <= wr_beats_d;
    end
  end

  assign rd_beats = rd_beats_q;
  assign wr_beats = wr_beats_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_mem_responder                                              |
// | Brief  : Directed self-checking bench for mem_responder (DEPTH=64,     |
// |          LAT=2, BASE=0). Stats checks active with MEM_RESP_STATS_EN.   |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read_enable = 1'b0;
  logic [63:0] read_addr = '0;
  logic [63:0] read_size_output = 64'd8;
  logic        finish_read = 1'b0;
  logic        write_enable = 1'b0;
  logic [63:0] write_addr = '0;
  logic [63:0] write_data = '0;
  logic [63:0] write_size = 64'd8;
  logic        finish_write = 1'b0;
  logic [63:0] read_ready, read_data, write_ready;
  logic        host_en = 1'b0;
  logic        host_we = 1'b0;
  logic [5:0]  host_addr = '0;
  logic [63:0] host_wdata = '0;
  logic [63:0] host_rdata;
  logic        host_ack;
  logic        err;
`ifdef MEM_RESP_STATS_EN
  logic [31:0] rd_beats, wr_beats;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  mem_responder #(.DEPTH(DEPTH), .LAT(LAT), .BASE(64'd0)) dut (
    .clk              (clk),
    .reset            (reset),
    .read_enable      (read_enable),
    .read_addr        (read_addr),
    .read_size_output (read_size_output),
    .finish_read      (finish_read),
    .write_enable     (write_enable),
    .write_addr       (write_addr),
    .write_data       (write_data),
    .write_size       (write_size),
    .finish_write     (finish_write),
    .read_ready       (read_ready),
    .read_data        (read_data),
    .write_ready      (write_ready),
    .host_en          (host_en),
    .host_we          (host_we),
    .host_addr        (host_addr),
    .host_wdata       (host_wdata),
    .host_rdata       (host_rdata),
    .host_ack         (host_ack),
`ifdef MEM_RESP_STATS_EN
    .rd_beats         (rd_beats),
    .wr_beats         (wr_beats),
`endif
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [5:0] idx, input logic [63:0] d);
    host_en = 1'b1; host_we = 1'b1; host_addr = idx; host_wdata = d;
    tick();
    host_en = 1'b0; host_we = 1'b0;
    check_eq("host_wr_ack", {63'd0, host_ack}, 64'd1);
  endtask

  task automatic host_read(input string tag, input logic [5:0] idx, input logic [63:0] exp);
    host_en = 1'b1; host_we = 1'b0; host_addr = idx;
    tick();
    host_en = 1'b0;
    check_eq({tag, "_ack"}, {63'd0, host_ack}, 64'd1);
    check_eq({tag, "_data"}, host_rdata, exp);
    tick();
    check_eq({tag, "_ack_drop"}, {63'd0, host_ack}, 64'd0);
  endtask

  // One read beat: opens the burst from IDLE (first) or acknowledges the
  // previous beat from ACK, then waits a bounded time for the ready pulse.
  task automatic rd_beat(input string tag, input logic first, input logic [63:0] addr,
                         input logic [63:0] exp);
    int n;
    if (first) read_enable = 1'b1;
    else       finish_read = 1'b1;
    read_addr = addr;
    tick();
    finish_read = 1'b0;
    n = 1;
    while (read_ready[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'(LAT + 1));
    check_eq({tag, "_rdy"}, read_ready, 64'd1);
    check_eq({tag, "_data"}, read_data, exp);
    check_eq({tag, "_wrdy_quiet"}, write_ready, 64'd0);
    tick();
    check_eq({tag, "_rdy_1cyc"}, read_ready, 64'd0);
  endtask

  task automatic wr_beat(input string tag, input logic first, input logic [63:0] addr,
                         input logic [63:0] d);
    int n;
    if (first) write_enable = 1'b1;
    else       finish_write = 1'b1;
    write_addr = addr;
    write_data = d;
    tick();
    finish_write = 1'b0;
    n = 1;
    while (write_ready[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'(LAT + 1));
    check_eq({tag, "_rdy"}, write_ready, 64'd1);
    check_eq({tag, "_rrdy_quiet"}, read_ready, 64'd0);
    tick();
    check_eq({tag, "_rdy_1cyc"}, write_ready, 64'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_read_ready", read_ready, 64'd0);
    check_eq("rst_write_ready", write_ready, 64'd0);
    check_eq("rst_read_data", read_data, 64'd0);
    check_eq("rst_host_ack", {63'd0, host_ack}, 64'd0);
    check_eq("rst_err", {63'd0, err}, 64'd0);
    reset = 1'b1;
    tick();

    // Test 1: preload, two-beat read from 0
    host_write(6'd0, 64'h11);
    host_write(6'd1, 64'h22);
    rd_beat("t1_b0", 1'b1, 64'h0, 64'h11);
    rd_beat("t1_b1", 1'b0, 64'h8, 64'h22);
    read_enable = 1'b0;
    tick();
    host_read("t1_idle", 6'd1, 64'h22);

    // Test 2: three-beat write at 0x10
    wr_beat("t2_b0", 1'b1, 64'h10, 64'hA);
    wr_beat("t2_b1", 1'b0, 64'h18, 64'hB);
    wr_beat("t2_b2", 1'b0, 64'h20, 64'hC);
    write_enable = 1'b0;
    tick();
    host_read("t2_m2", 6'd2, 64'hA);
    host_read("t2_m3", 6'd3, 64'hB);
    host_read("t2_m4", 6'd4, 64'hC);
`ifdef MEM_RESP_STATS_EN
    check_eq("t6_rd_beats", {32'd0, rd_beats}, 64'd2);
    check_eq("t6_wr_beats", {32'd0, wr_beats}, 64'd3);
`endif
    check_eq("t2_err", {63'd0, err}, 64'd0);

    // Test 3: both enables together, read served first
    write_enable = 1'b1;
    write_addr   = 64'h28;
    write_data   = 64'hD;
    rd_beat("t3_rd", 1'b1, 64'h8, 64'h22);
    read_enable = 1'b0;
    tick();
    check_eq("t3_wrdy_idle", write_ready, 64'd0);
    wr_beat("t3_wr", 1'b1, 64'h28, 64'hD);
    write_enable = 1'b0;
    tick();
    host_read("t3_m5", 6'd5, 64'hD);
    check_eq("t3_err", {63'd0, err}, 64'd0);

    // Test 4: out-of-range read, then misaligned write dropped
    rd_beat("t4_oor", 1'b1, 64'(8 * DEPTH), 64'h0);
    check_eq("t4_err", {63'd0, err}, 64'd1);
    read_enable = 1'b0;
    tick();
    wr_beat("t4_mis", 1'b1, 64'h3, 64'hDEAD);
    write_enable = 1'b0;
    tick();
    host_read("t4_m0", 6'd0, 64'h11);
    check_eq("t4_err_sticky", {63'd0, err}, 64'd1);

    // Test 5: reset while in WAIT
    write_enable = 1'b1;
    write_addr   = 64'h0;
    write_data   = 64'hEE;
    tick();
    #1;
    reset = 1'b0;
    #1;
    check_eq("t5_wrdy", write_ready, 64'd0);
    check_eq("t5_rrdy", read_ready, 64'd0);
    check_eq("t5_err", {63'd0, err}, 64'd0);
    check_eq("t5_host_ack", {63'd0, host_ack}, 64'd0);
`ifdef MEM_RESP_STATS_EN
    check_eq("t5_rd_beats", {32'd0, rd_beats}, 64'd0);
    check_eq("t5_wr_beats", {32'd0, wr_beats}, 64'd0);
`endif
    tick();
    write_enable = 1'b0;
    reset = 1'b1;
    tick();
    host_read("t5_m0", 6'd0, 64'h11);
    host_read("t5_m3", 6'd3, 64'hB);
    check_eq("t5_err_after", {63'd0, err}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
